ice_risc_mem_arb: RTL and testbench
===================================

ICE_RISC_MEM_ARB -- requirements
Module: ice_risc_mem_arb

Interface
REQ-001 Parameter pTimeout, default 255, max cycles in ISSUE+WAIT before forced error completion (range 1..65535).
REQ-002 iwClk  in  1  sole clock; all state on rising edge.
REQ-003 iwRst  in  1  asynchronous, active-high reset.
REQ-004 iwReq  in  3  per-requester request; bit0 instruction fetch, bit1 data read, bit2 data write.
REQ-005 iwAddr  in  96  per-requester byte address, requester n at bits [32n+31:32n].
REQ-006 iwWData  in  32  write data (requester 2 only).
REQ-007 iwWstrb  in  4  byte strobes (requester 2 only).
REQ-008 owAck  out  3  one-cycle completion pulse, one-hot, to the granted requester.
REQ-009 owRData  out  32  read data, valid while owAck nonzero.
REQ-010 owErr  out  1  completion was a timeout, valid while owAck nonzero.
REQ-011 owMemValid/owMemWrite  out  1/1  memory command valid; command is a write.
REQ-012 owMemAddr/owMemWData/owMemWstrb  out  32/32/4  registered command fields.
REQ-013 iwMemReady  in  1  memory accepts command when high with owMemValid.
REQ-014 iwMemRValid/iwMemRData  in  1/32  read response strobe and data.
REQ-015 owBusy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, ACK.
REQ-017 IDLE: if iwReq!=0, pick one requester, latch its address/data/strobe (strobe 4'hF ignored for reads), go ISSUE; else stay.
REQ-018 ISSUE: owMemValid=1 with latched fields; on iwMemReady, write -> ACK, read -> WAIT.
REQ-019 WAIT: on iwMemRValid latch iwMemRData, go ACK; iwMemRValid in any other state SHALL be ignored.
REQ-020 ACK: exactly one cycle, owAck[grant]=1, owErr as latched, then IDLE; writes return owRData=0.
REQ-021 Minimum latency req-to-ack: write 3 cycles, read 4 cycles, with ready/rvalid in first eligible cycle.
REQ-022 Timeout counter SHALL clear on IDLE->ISSUE, increment each ISSUE/WAIT cycle; on reaching pTimeout go ACK with owErr=1, owRData=0, owMemValid low that cycle.
REQ-023 Requester SHALL hold req/fields until its ack; deasserting req mid-transaction SHALL NOT cancel it.
REQ-024 Requester still asserting req in the IDLE cycle after its ACK is a new request.
REQ-025 Simultaneous iwMemReady and timeout expiry: acceptance wins (no error).
REQ-026 Only one transaction outstanding; all memory outputs registered.

Reset
REQ-027 On iwRst: state IDLE, owMemValid=0, owAck=0, owErr=0, owBusy=0, owRData=0, all mem fields 0, counter 0, last-grant pointer 2.
REQ-028 Reset mid-transaction SHALL drop owMemValid immediately (asynchronously) and discard the transaction with no ack.

Configuration
REQ-029 Macro ICE_RISC_ARB_RR_EN defined: round-robin, search order starts at requester after last grant (after reset: 0,1,2).
REQ-030 Macro undefined: fixed priority 2 > 1 > 0; last-grant pointer unused.

Structure
REQ-031 Package ice_risc_arb_pkg SHALL hold state enum, requester index constants (REQ_IFETCH=0, REQ_DREAD=1, REQ_DWRITE=2), NUM_REQ=3, address/data widths.
REQ-032 Sub-module ice_risc_rr_pick: combinational 3-way priority picker (request vector, pointer in; one-hot grant out), used in both modes.

Verification
REQ-033 Single read: iwReq=3'b001, addr 0x100, ready at once, rvalid+0xDEADBEEF next -> owAck=3'b001, owRData=0xDEADBEEF at cycle 4.
REQ-034 Write: iwReq=3'b100, addr 0x200, data 0x12345678, wstrb 4'b0011 -> owMemWrite=1 with those fields, owAck=3'b100 at cycle 3, owRData=0.
REQ-035 All three held high, RR build -> ack order 0,1,2,0; fixed build -> 2,2,2 while bit2 held.
REQ-036 iwMemReady held low, pTimeout=4 -> ack with owErr=1 after 4 ISSUE cycles, FSM back to IDLE.
REQ-037 iwRst pulsed during WAIT -> owMemValid/owBusy low immediately, no ack; late iwMemRValid ignored.
REQ-038 iwMemRValid pulsed while IDLE -> no ack, no state change.

Source files
------------

// File: rtl/ice_risc_arb_pkg.sv
// Shared types and constants for the ice_risc memory arbiter: FSM state,
// requester indices and bus widths.
package ice_risc_arb_pkg;

  localparam int NUM_REQ    = 3;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = 4;

  localparam int REQ_IFETCH = 0;
  localparam int REQ_DREAD  = 1;
  localparam int REQ_DWRITE = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/ice_risc_mem_arb_if.sv
// Requester and memory-side signals of the arbiter. The slave modport is the
// arbiter's view; the master modport is the requesters plus memory.
interface ice_risc_mem_arb_if;
  import ice_risc_arb_pkg::*;

  // Handshake: a memory command transfers on a rising edge where owMemValid
  // and iwMemReady are both high; owMemValid and its fields stay stable until
  // then. iwMemRValid is a one-cycle strobe, only honoured while waiting for
  // read data. owAck is a one-cycle pulse; requesters hold iwReq and their
  // fields until they see it.
  logic [NUM_REQ-1:0]        iwReq;
  logic [NUM_REQ*ADDR_W-1:0] iwAddr;
  logic [DATA_W-1:0]         iwWData;
  logic [STRB_W-1:0]         iwWstrb;
  logic [NUM_REQ-1:0]        owAck;
  logic [DATA_W-1:0]         owRData;
  logic                      owErr;
  logic                      owMemValid;
  logic                      owMemWrite;
  logic [ADDR_W-1:0]         owMemAddr;
  logic [DATA_W-1:0]         owMemWData;
  logic [STRB_W-1:0]         owMemWstrb;
  logic                      iwMemReady;
  logic                      iwMemRValid;
  logic [DATA_W-1:0]         iwMemRData;
  logic                      owBusy;

  modport slave (
    input  iwReq, iwAddr, iwWData, iwWstrb, iwMemReady, iwMemRValid, iwMemRData,
    output owAck, owRData, owErr, owMemValid, owMemWrite, owMemAddr,
           owMemWData, owMemWstrb, owBusy
  );

  modport master (
    output iwReq, iwAddr, iwWData, iwWstrb, iwMemReady, iwMemRValid, iwMemRData,
    input  owAck, owRData, owErr, owMemValid, owMemWrite, owMemAddr,
           owMemWData, owMemWstrb, owBusy
  );

endinterface

// File: rtl/ice_risc_rr_pick.sv
// Combinational 3-way requester picker. Round-robin (search starts after
// iwPtr) when pRoundRobin is set, otherwise fixed priority 2 > 1 > 0.
module ice_risc_rr_pick
  import ice_risc_arb_pkg::*;
#(
  parameter bit pRoundRobin = 1'b0
) (
  input  logic [NUM_REQ-1:0] iwReq,
  input  logic [1:0]         iwPtr,
  output logic [NUM_REQ-1:0] owGrant
);

  always_comb begin
    owGrant = '0;
    if (pRoundRobin) begin
      case (iwPtr)
        2'd0: begin
          if      (iwReq[1]) owGrant = 3'b010;
          else if (iwReq[2]) owGrant = 3'b100;
          else if (iwReq[0]) owGrant = 3'b001;
        end
        2'd1: begin
          if      (iwReq[2]) owGrant = 3'b100;
          else if (iwReq[0]) owGrant = 3'b001;
          else if (iwReq[1]) owGrant = 3'b010;
        end
        default: begin
          if      (iwReq[0]) owGrant = 3'b001;
          else if (iwReq[1]) owGrant = 3'b010;
          else if (iwReq[2]) owGrant = 3'b100;
        end
      endcase
    end else begin
      if      (iwReq[2]) owGrant = 3'b100;
      else if (iwReq[1]) owGrant = 3'b010;
      else if (iwReq[0]) owGrant = 3'b001;
    end
  end

endmodule

// File: rtl/ice_risc_mem_arb.sv
// Three-requester single-outstanding memory arbiter with timeout.
// Define ICE_RISC_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module ice_risc_mem_arb
  import ice_risc_arb_pkg::*;
#(
  parameter int pTimeout = 255
) (
  input  logic                iwClk,
  input  logic                iwRst,
  ice_risc_mem_arb_if.slave   bus,
  output state_t              owDbgState
);

`ifdef ICE_RISC_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic [16:0] TIMEOUT = 17'(pTimeout);

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  pick;
  logic [1:0]          pick_idx;
  logic [1:0]          ptr_q;
  logic [15:0]         cnt_q, cnt_d;
  logic [16:0]         cnt_inc;
  logic                expire;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

  ice_risc_rr_pick #(.pRoundRobin(RR_EN)) u_pick (
    .iwReq   (bus.iwReq),
    .iwPtr   (ptr_q),
    .owGrant (pick)
  );

  assign pick_idx = onehot_to_idx(pick);
  // Counter value this cycle would reach; expiry fires on the cycle it hits the limit.
  assign cnt_inc  = {1'b0, cnt_q} + 17'd1;
  assign expire   = (cnt_inc >= TIMEOUT);

`ifdef ICE_RISC_ARB_RR_EN
  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      ptr_q <= 2'd2;
    end else if (state_q == ST_IDLE && |bus.iwReq) begin
      ptr_q <= pick_idx;
    end
  end
`else
  assign ptr_q = 2'd2;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_valid_d = mem_valid_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.iwReq) begin
          state_d     = ST_ISSUE;
          grant_d     = pick;
          cnt_d       = '0;
          err_d       = 1'b0;
          rdata_d     = '0;
          mem_valid_d = 1'b1;
          mem_write_d = (pick_idx == 2'(REQ_DWRITE));
          case (pick_idx)
            2'd0:    mem_addr_d = bus.iwAddr[31:0];
            2'd1:    mem_addr_d = bus.iwAddr[63:32];
            default: mem_addr_d = bus.iwAddr[95:64];
          endcase
          if (pick_idx == 2'(REQ_DWRITE)) begin
            mem_wdata_d = bus.iwWData;
            mem_wstrb_d = bus.iwWstrb;
          end else begin
            mem_wdata_d = '0;
            mem_wstrb_d = 4'hF;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_inc[15:0];
        // Acceptance is checked first so it wins over a simultaneous expiry.
        if (bus.iwMemReady) begin
          mem_valid_d = 1'b0;
          state_d     = mem_write_q ? ST_ACK : ST_WAIT;
        end else if (expire) begin
          mem_valid_d = 1'b0;
          err_d       = 1'b1;
          state_d     = ST_ACK;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc[15:0];
        if (bus.iwMemRValid) begin
          rdata_d = bus.iwMemRData;
          state_d = ST_ACK;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign bus.owAck      = (state_q == ST_ACK) ? grant_q : '0;
  assign bus.owErr      = (state_q == ST_ACK) && err_q;
  assign bus.owRData    = rdata_q;
  assign bus.owBusy     = (state_q != ST_IDLE);
  assign bus.owMemValid = mem_valid_q;
  assign bus.owMemWrite = mem_write_q;
  assign bus.owMemAddr  = mem_addr_q;
  assign bus.owMemWData = mem_wdata_q;
  assign bus.owMemWstrb = mem_wstrb_q;
  assign owDbgState     = state_q;

endmodule

// File: tb/tb_ice_risc_mem_arb.sv
// Self-checking bench for ice_risc_mem_arb: a memory responder, an ack
// scoreboard fed by the stimulus tasks, and one task per scenario.
module tb_ice_risc_mem_arb;
  import ice_risc_arb_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  ice_risc_mem_arb_if bus();

  ice_risc_mem_arb #(.pTimeout(4)) dut (
    .iwClk      (clk),
    .iwRst      (rst),
    .bus        (bus),
    .owDbgState (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_vec   = 0;
  int          n_miss  = 0;
  int          ack_cnt = 0;
  logic [35:0] exp_q[$];   // {ack, err, rdata}
  logic        ready_en = 1'b0;
  int          rd_lat   = 1;
  int          rd_cnt   = 0;
  logic [31:0] rd_addr  = '0;

  assign bus.iwMemReady = ready_en;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a ^ 32'h5A5A_0000) + 32'h11;
  endfunction

  // Memory responder: returns read data rd_lat cycles after a read is accepted.
  always begin
    @(negedge clk);
    #2;
    bus.iwMemRValid = 1'b0;
    bus.iwMemRData  = '0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        bus.iwMemRValid = 1'b1;
        bus.iwMemRData  = mem_model(rd_addr);
      end
    end
    if (!rst && bus.owMemValid && bus.iwMemReady && !bus.owMemWrite) begin
      rd_cnt  = rd_lat;
      rd_addr = bus.owMemAddr;
    end
  end

  // Scoreboard: every ack is matched against the oldest expected completion.
  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst && bus.owAck != '0) begin
      ack_cnt++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_ack ack=%b err=%b rdata=%h", bus.owAck, bus.owErr, bus.owRData);
      end else begin
        e = exp_q.pop_front();
        if ({bus.owAck, bus.owErr, bus.owRData} !== e) begin
          n_miss++;
          $display("FAIL ack_data got ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h",
                   bus.owAck, bus.owErr, bus.owRData, e[35:33], e[32], e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.iwReq   = '0;
    bus.iwAddr  = '0;
    bus.iwWData = '0;
    bus.iwWstrb = '0;
    ready_en    = 1'b0;
    rd_lat      = 1;
    rd_cnt      = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.iwReq   = '0;
    bus.iwAddr  = '0;
    bus.iwWData = '0;
    bus.iwWstrb = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.owMemValid, bus.owMemWrite, bus.owMemAddr, bus.owMemWData, bus.owMemWstrb,
         bus.owAck, bus.owErr, bus.owBusy, bus.owRData} !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs valid=%b write=%b addr=%h wdata=%h wstrb=%h ack=%b err=%b busy=%b rdata=%h want all zero",
               bus.owMemValid, bus.owMemWrite, bus.owMemAddr, bus.owMemWData, bus.owMemWstrb,
               bus.owAck, bus.owErr, bus.owBusy, bus.owRData);
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_miss++;
      $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE);
    end
    rst = 1'b0;
    repeat (2) step();
    n_vec++;
    if ({bus.owBusy, bus.owMemValid} !== 2'b00) begin
      n_miss++;
      $display("FAIL idle_after_reset busy=%b valid=%b want 0 0", bus.owBusy, bus.owMemValid);
    end
  endtask

  task automatic test_single_read();
    int lat = 1;
    bit got = 0;
    ready_en   = 1'b1;
    rd_lat     = 1;
    bus.iwAddr = {64'h0, 32'h0000_0100};
    bus.iwReq  = 3'b001;
    exp_q.push_back({3'b001, 1'b0, 32'hDEADBEEF});
    while (!got && lat < 20) begin
      step();
      lat++;
      if (lat == 2) begin
        n_vec++;
        if ({bus.owMemValid, bus.owMemWrite, bus.owMemAddr} !== {1'b1, 1'b0, 32'h100}) begin
          n_miss++;
          $display("FAIL rd_issue valid=%b write=%b addr=%h want 1 0 00000100",
                   bus.owMemValid, bus.owMemWrite, bus.owMemAddr);
        end
      end
      if (bus.owAck != '0) got = 1;
    end
    bus.iwReq = '0;
    n_vec++;
    if (lat != 4) begin
      n_miss++;
      $display("FAIL rd_latency got=%0d want=4", lat);
    end
    step();
  endtask

  task automatic test_write();
    int lat = 1;
    bit got = 0;
    ready_en    = 1'b1;
    bus.iwAddr  = {32'h0000_0200, 64'h0};
    bus.iwWData = 32'h1234_5678;
    bus.iwWstrb = 4'b0011;
    bus.iwReq   = 3'b100;
    exp_q.push_back({3'b100, 1'b0, 32'h0});
    while (!got && lat < 20) begin
      step();
      lat++;
      if (lat == 2) begin
        n_vec++;
        if ({bus.owMemValid, bus.owMemWrite, bus.owMemAddr, bus.owMemWData, bus.owMemWstrb}
            !== {1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'b0011}) begin
          n_miss++;
          $display("FAIL wr_issue valid=%b write=%b addr=%h wdata=%h wstrb=%b want 1 1 00000200 12345678 0011",
                   bus.owMemValid, bus.owMemWrite, bus.owMemAddr, bus.owMemWData, bus.owMemWstrb);
        end
      end
      if (bus.owAck != '0) got = 1;
    end
    bus.iwReq = '0;
    n_vec++;
    if (lat != 3) begin
      n_miss++;
      $display("FAIL wr_latency got=%0d want=3", lat);
    end
    step();
  endtask

  task automatic test_timeout();
    int lat = 1;
    int issue_cyc = 0;
    bit got = 0;
    ready_en   = 1'b0;
    bus.iwAddr = {64'h0, 32'h0000_0400};
    bus.iwReq  = 3'b001;
    exp_q.push_back({3'b001, 1'b1, 32'h0});
    while (!got && lat < 30) begin
      step();
      lat++;
      if (bus.owAck != '0) begin
        got = 1;
        n_vec++;
        if (bus.owMemValid !== 1'b0) begin
          n_miss++;
          $display("FAIL to_valid_at_ack got=%b want=0", bus.owMemValid);
        end
      end else if (bus.owMemValid) begin
        issue_cyc++;
      end
    end
    bus.iwReq = '0;
    n_vec++;
    if (issue_cyc != 4 || lat != 6) begin
      n_miss++;
      $display("FAIL to_cycles issue=%0d lat=%0d want issue=4 lat=6", issue_cyc, lat);
    end
    step();
    n_vec++;
    if ({dbg_state, bus.owBusy} !== {ST_IDLE, 1'b0}) begin
      n_miss++;
      $display("FAIL to_idle state=%0d busy=%b want 0 0", dbg_state, bus.owBusy);
    end
  endtask

  task automatic test_accept_at_expiry();
    int lat = 1;
    bit got = 0;
    ready_en   = 1'b0;
    rd_lat     = 1;
    bus.iwAddr = {64'h0, 32'h0000_0500};
    bus.iwReq  = 3'b001;
    exp_q.push_back({3'b001, 1'b0, mem_model(32'h500)});
    while (!got && lat < 30) begin
      step();
      lat++;
      if (lat == 5) ready_en = 1'b1;
      if (bus.owAck != '0) got = 1;
    end
    bus.iwReq = '0;
    ready_en  = 1'b0;
    n_vec++;
    if (lat != 7) begin
      n_miss++;
      $display("FAIL expiry_accept_latency got=%0d want=7", lat);
    end
    step();
  endtask

  task automatic test_arbitration();
    int seen = 0;
    int cyc = 0;
    int n_exp;
    do_reset();
    ready_en    = 1'b1;
    rd_lat      = 1;
    bus.iwAddr  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    bus.iwWData = 32'hCAFE_0002;
    bus.iwWstrb = 4'hF;
`ifdef ICE_RISC_ARB_RR_EN
    n_exp = 4;
    exp_q.push_back({3'b001, 1'b0, mem_model(32'h1000)});
    exp_q.push_back({3'b010, 1'b0, mem_model(32'h2000)});
    exp_q.push_back({3'b100, 1'b0, 32'h0});
    exp_q.push_back({3'b001, 1'b0, mem_model(32'h1000)});
`else
    n_exp = 3;
    repeat (3) exp_q.push_back({3'b100, 1'b0, 32'h0});
`endif
    bus.iwReq = 3'b111;
    while (seen < n_exp && cyc < 60) begin
      step();
      cyc++;
      if (bus.owAck != '0) begin
        seen++;
        if (seen == n_exp) bus.iwReq = '0;
      end
    end
    bus.iwReq = '0;
    n_vec++;
    if (seen != n_exp) begin
      n_miss++;
      $display("FAIL arb_ack_count got=%0d want=%0d", seen, n_exp);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int acks_before;
    ready_en   = 1'b0;
    bus.iwAddr = {32'h0, 32'h0000_0600, 32'h0};
    bus.iwReq  = 3'b010;
    step();
    n_vec++;
    if (bus.owMemValid !== 1'b1) begin
      n_miss++;
      $display("FAIL mid_issue_valid got=%b want=1", bus.owMemValid);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.owMemValid, bus.owBusy} !== 2'b00) begin
      n_miss++;
      $display("FAIL async_drop_issue valid=%b busy=%b want 0 0", bus.owMemValid, bus.owBusy);
    end
    bus.iwReq = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    ready_en   = 1'b1;
    rd_lat     = 4;
    bus.iwAddr = {32'h0, 32'h0000_0700, 32'h0};
    bus.iwReq  = 3'b010;
    step();
    step();
    n_vec++;
    if (dbg_state !== ST_WAIT) begin
      n_miss++;
      $display("FAIL mid_wait_state got=%0d want=%0d", dbg_state, ST_WAIT);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.owMemValid, bus.owBusy, dbg_state} !== {1'b0, 1'b0, ST_IDLE}) begin
      n_miss++;
      $display("FAIL async_drop_wait valid=%b busy=%b state=%0d want 0 0 0",
               bus.owMemValid, bus.owBusy, dbg_state);
    end
    bus.iwReq = '0;
    ready_en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acks_before = ack_cnt;
    repeat (6) step();
    n_vec++;
    if (ack_cnt != acks_before || dbg_state !== ST_IDLE) begin
      n_miss++;
      $display("FAIL reset_discard acks=%0d want=%0d state=%0d want=0", ack_cnt, acks_before, dbg_state);
    end
    rd_lat = 1;
  endtask

  task automatic test_idle_rvalid();
    int acks_before = ack_cnt;
    rd_addr = 32'h0000_0100;
    rd_cnt  = 1;
    repeat (4) step();
    n_vec++;
    if (ack_cnt != acks_before || dbg_state !== ST_IDLE || bus.owBusy !== 1'b0) begin
      n_miss++;
      $display("FAIL idle_rvalid acks=%0d want=%0d state=%0d busy=%b want 0 0",
               ack_cnt, acks_before, dbg_state, bus.owBusy);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      int          r;
      int          lat;
      int          want_lat;
      bit          got;
      logic [31:0] a;
      r           = $urandom_range(0, 2);
      a           = $urandom & 32'h0000_FFFC;
      rd_lat      = $urandom_range(1, 2);
      ready_en    = 1'b1;
      bus.iwAddr  = {$urandom, $urandom, $urandom};
      bus.iwAddr[r*32 +: 32] = a;
      bus.iwWData = $urandom;
      bus.iwWstrb = 4'($urandom_range(1, 15));
      bus.iwReq   = 3'(1 << r);
      exp_q.push_back({3'(1 << r), 1'b0, (r == 2) ? 32'h0 : mem_model(a)});
      want_lat = (r == 2) ? 3 : 3 + rd_lat;
      lat = 1;
      got = 0;
      while (!got && lat < 20) begin
        step();
        lat++;
        if (bus.owAck != '0) got = 1;
      end
      bus.iwReq = '0;
      n_vec++;
      if (lat != want_lat) begin
        n_miss++;
        $display("FAIL b2b_latency iter=%0d req=%0d got=%0d want=%0d", i, r, lat, want_lat);
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_write();
    test_timeout();
    test_accept_at_expiry();
    test_arbitration();
    test_reset_mid();
    test_idle_rvalid();
    test_back_to_back();
    repeat (2) step();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench did not complete");
  end

endmodule
